// File: rtl/transform_reorder.sv
// Bit-reversal reorder buffer: accepts N-point frames in bit-reversed order and emits
// them in natural order through a two-bank ping-pong memory at full streaming rate.
module transform_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_last
);

  localparam int AW = $clog2(N);

  generate
    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("transform_reorder: N must be a power of two and at least 4");
    end
  endgenerate

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Bank b occupies addresses {b, slot}
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [1:0]    full;
  logic [1:0]    full_next;
  logic          wsel;
  logic          rsel;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic          wr_en;
  logic          wr_wrap;
  logic          rd_load;
  logic          rd_wrap;

  assign s_ready = ~full[wsel];

  // Handshake decode and bank-flag update; writer and reader never touch the same bank
  always_comb begin
    wr_en     = s_valid && s_ready;
    wr_wrap   = wr_en && (wcnt == AW'(N - 1));
    rd_load   = full[rsel] && (!m_valid || m_ready);
    rd_wrap   = rd_load && (rcnt == AW'(N - 1));
    full_next = full;
    if (wr_wrap) begin
      full_next[wsel] = 1'b1;
    end else begin
      full_next[wsel] = full[wsel];
    end
    if (rd_wrap) begin
      full_next[rsel] = 1'b0;
    end else begin
      full_next[rsel] = full_next[rsel];
    end
  end

  // Control state: counters, bank selects, bank flags and output handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 2'b00;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      wcnt    <= '0;
      rcnt    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wr_wrap) begin
          wsel <= ~wsel;
        end
      end
      if (rd_load) begin
        rcnt    <= rcnt + 1'b1;
        m_valid <= 1'b1;
        m_last  <= rd_wrap;
        if (rd_wrap) begin
          rsel <= ~rsel;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Bank RAM: scattered write at the bit-reversed slot, synchronous read into the output register
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wsel, bitrev(wcnt)}] <= s_data;
    end
    if (rd_load) begin
      m_data <= mem[{rsel, rcnt}];
    end
  end

endmodule
